// File: rtl/tx_mux_pkg.sv
// Shared constants for the TX priority mux: FSM encoding, comma symbol, idle word, boundary test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_mux_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam logic [7:0]  K28_5          = 8'hBC;
  localparam logic [15:0] IDLE_DATA_DEF  = 16'h50BC;
  localparam logic [1:0]  IDLE_KCHAR_DEF = 2'b01;

  // A word is a safe switch point when its first byte is a K28.5 comma.
  function automatic logic is_boundary(input logic [7:0] byte0, input logic k0);
    return k0 && (byte0 == K28_5);
  endfunction

endpackage

// File: rtl/tx_prio_enc.sv
// Lowest-index-wins priority encoder; returns NSRC when no enable is set.
// Latency: combinational.
// Backpressure: none.
module tx_prio_enc #(
  parameter int NSRC = 3
) (
  input  logic [NSRC-1:0]            en,
  output logic [$clog2(NSRC+1)-1:0]  req
);

  localparam int SW = $clog2(NSRC+1);

  // Scan from the top so the lowest enabled index is the last to write.
  always_comb begin
    req = SW'(NSRC);
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (en[i]) req = SW'(i);
    end
  end

endmodule

// File: rtl/tx_prio_mux.sv
// N-source priority mux onto the PCS TX word bus; switches only at comma boundaries plus an idle guard run.
// Latency: 1 TX_CLK from selected source to TX_DATA; OFF->PASS first word 2 edges after enable.
// Backpressure: none; sources free-run and the PCS takes a word every cycle, long waits end in a forced switch.
module tx_prio_mux
  import tx_mux_pkg::*;
#(
  parameter int            NSRC       = 3,
  parameter int            DW         = 16,
  parameter int            KW         = DW / 8,
  parameter logic [DW-1:0] IDLE_DATA  = DW'(IDLE_DATA_DEF),
  parameter logic [KW-1:0] IDLE_KCHAR = KW'(IDLE_KCHAR_DEF),
  parameter int            GUARD      = 2,
  parameter int            DRAIN_MAX  = 64
) (
  input  logic                        TX_CLK,
  input  logic                        RESET_N,
  input  logic [NSRC-1:0]             SRC_EN,
  input  logic [NSRC*DW-1:0]          SRC_DATA,
  input  logic [NSRC*KW-1:0]          SRC_KCHAR,
  output logic [DW-1:0]               TX_DATA,
  output logic [KW-1:0]               TX_KCHAR,
  output logic [$clog2(NSRC+1)-1:0]   ACTIVE_SRC,
  output logic [15:0]                 SWITCH_CNT,
  output logic                        FORCED,
  input  logic                        CNT_CLR
);

  localparam int SW  = $clog2(NSRC+1);
  localparam int CW  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;

  logic [DW-1:0]  src_dat [NSRC];
  logic [KW-1:0]  src_kch [NSRC];

  logic [SW-1:0]  req;
  logic [1:0]     state, state_nxt;
  logic [CW-1:0]  cur, cur_nxt;
  logic [DCW-1:0] drain_cnt, drain_nxt;
  logic [GCW-1:0] guard_cnt, guard_nxt;
  logic           load_src;
  logic           inc_sw;
  logic           force_nxt;
  logic           cur_en;
  logic           cur_bnd;
  logic           req_none;
  logic           req_cur;

  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign src_dat[g] = SRC_DATA[g*DW +: DW];
    assign src_kch[g] = SRC_KCHAR[g*KW +: KW];
  end

  tx_prio_enc #(.NSRC(NSRC)) u_enc (
    .en  (SRC_EN),
    .req (req)
  );

  assign cur_en   = SRC_EN[cur];
  assign cur_bnd  = is_boundary(src_dat[cur][7:0], src_kch[cur][0]);
  assign req_none = (req == SW'(NSRC));
  assign req_cur  = (req == SW'(cur));

  // Next-state decode: which word goes out next and where the selection moves.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    drain_nxt = drain_cnt;
    guard_nxt = guard_cnt;
    load_src  = 1'b0;
    inc_sw    = 1'b0;
    force_nxt = 1'b0;
    case (state)
      ST_OFF: begin
        if (!req_none) begin
          state_nxt = ST_PASS;
          cur_nxt   = req[CW-1:0];
          inc_sw    = 1'b1;
        end
      end
      ST_PASS: begin
        if (!cur_en) begin
          // Owner vanished mid-stream: nothing safe to wait for, cut to idle now.
          state_nxt = req_none ? ST_OFF : ST_GUARD;
          guard_nxt = '0;
        end else begin
          load_src = 1'b1;
          if (!req_cur) begin
            state_nxt = ST_DRAIN;
            drain_nxt = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (req_cur) begin
          load_src  = 1'b1;
          state_nxt = ST_PASS;
        end else if (!cur_en) begin
          state_nxt = ST_GUARD;
          guard_nxt = '0;
        end else if (cur_bnd) begin
          // The comma itself still belongs to the old source.
          load_src  = 1'b1;
          state_nxt = ST_GUARD;
          guard_nxt = '0;
        end else if (drain_cnt == DCW'(DRAIN_MAX - 1)) begin
          force_nxt = 1'b1;
          state_nxt = ST_GUARD;
          guard_nxt = '0;
        end else begin
          load_src  = 1'b1;
          drain_nxt = drain_cnt + DCW'(1);
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GCW'(GUARD - 1)) begin
          // Re-arbitrate at the end of the gap so a late request still wins.
          if (req_none) begin
            state_nxt = ST_OFF;
          end else begin
            state_nxt = ST_PASS;
            cur_nxt   = req[CW-1:0];
            inc_sw    = 1'b1;
          end
        end else begin
          guard_nxt = guard_cnt + GCW'(1);
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Control state registers.
  always_ff @(posedge TX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_OFF;
      cur       <= '0;
      drain_cnt <= '0;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      drain_cnt <= drain_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  // Output word register; ACTIVE_SRC tracks the word it is loaded with.
  always_ff @(posedge TX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_DATA    <= IDLE_DATA;
      TX_KCHAR   <= IDLE_KCHAR;
      ACTIVE_SRC <= SW'(NSRC);
      FORCED     <= 1'b0;
    end else begin
      TX_DATA    <= load_src ? src_dat[cur] : IDLE_DATA;
      TX_KCHAR   <= load_src ? src_kch[cur] : IDLE_KCHAR;
      ACTIVE_SRC <= load_src ? SW'(cur) : SW'(NSRC);
      FORCED     <= force_nxt;
    end
  end

  // Saturating selection counter; a clear on the same edge beats an increment.
  always_ff @(posedge TX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SWITCH_CNT <= '0;
    end else if (CNT_CLR) begin
      SWITCH_CNT <= '0;
    end else if (inc_sw && (SWITCH_CNT != 16'hFFFF)) begin
      SWITCH_CNT <= SWITCH_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_prio_mux.sv
// Bench for tx_prio_mux: directed scenarios plus random traffic against a word-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_prio_mux;

  localparam int NSRC      = 3;
  localparam int GUARD     = 2;
  localparam int DRAIN_MAX = 64;

  logic        TX_CLK;
  logic        RESET_N;
  logic [2:0]  SRC_EN;
  logic [15:0] sd [3];
  logic [1:0]  sk [3];
  logic [47:0] SRC_DATA;
  logic [5:0]  SRC_KCHAR;
  logic [15:0] TX_DATA;
  logic [1:0]  TX_KCHAR;
  logic [1:0]  ACTIVE_SRC;
  logic [15:0] SWITCH_CNT;
  logic        FORCED;
  logic        CNT_CLR;

  int total = 0;
  int bad   = 0;

  assign SRC_DATA  = {sd[2], sd[1], sd[0]};
  assign SRC_KCHAR = {sk[2], sk[1], sk[0]};

  tx_prio_mux dut (
    .TX_CLK     (TX_CLK),
    .RESET_N    (RESET_N),
    .SRC_EN     (SRC_EN),
    .SRC_DATA   (SRC_DATA),
    .SRC_KCHAR  (SRC_KCHAR),
    .TX_DATA    (TX_DATA),
    .TX_KCHAR   (TX_KCHAR),
    .ACTIVE_SRC (ACTIVE_SRC),
    .SWITCH_CNT (SWITCH_CNT),
    .FORCED     (FORCED),
    .CNT_CLR    (CNT_CLR)
  );

  initial TX_CLK = 1'b0;
  always #5 TX_CLK = ~TX_CLK;

  // Reference model: owner = source holding the link (-1 none), gap = idle words
  // still owed before re-arbitration, waited = cycles spent waiting for a comma (-1 not waiting).
  int          m_owner  = -1;
  int          m_gap    = 0;
  int          m_wait   = -1;
  logic [15:0] m_data   = 16'h50BC;
  logic [1:0]  m_k      = 2'b01;
  int          m_act    = NSRC;
  int          m_cnt    = 0;
  logic        m_forced = 1'b0;

  always @(posedge TX_CLK or negedge RESET_N) begin : model
    int  r;
    bit  grant;
    bit  send;
    if (!RESET_N) begin
      m_owner = -1; m_gap = 0; m_wait = -1;
      m_data = 16'h50BC; m_k = 2'b01; m_act = NSRC; m_cnt = 0; m_forced = 1'b0;
    end else begin
      r = NSRC;
      for (int i = NSRC - 1; i >= 0; i--) if (SRC_EN[i]) r = i;
      grant = 0; send = 0; m_forced = 1'b0;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          if (r < NSRC) begin m_owner = r; grant = 1; end else m_owner = -1;
        end
      end else if (m_owner < 0) begin
        if (r < NSRC) begin m_owner = r; grant = 1; end
      end else if (!SRC_EN[m_owner]) begin
        if (m_wait >= 0 || r < NSRC) m_gap = GUARD; else m_owner = -1;
        m_wait = -1;
      end else if (r == m_owner) begin
        send = 1; m_wait = -1;
      end else if (m_wait < 0) begin
        send = 1; m_wait = 0;
      end else if (sk[m_owner][0] && sd[m_owner][7:0] == 8'hBC) begin
        send = 1; m_gap = GUARD; m_wait = -1;
      end else if (m_wait == DRAIN_MAX - 1) begin
        m_forced = 1'b1; m_gap = GUARD; m_wait = -1;
      end else begin
        send = 1; m_wait++;
      end
      if (send) begin
        m_data = sd[m_owner]; m_k = sk[m_owner]; m_act = m_owner;
      end else begin
        m_data = 16'h50BC; m_k = 2'b01; m_act = NSRC;
      end
      if (CNT_CLR) m_cnt = 0;
      else if (grant && m_cnt < 16'hFFFF) m_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare every output against the model.
  task automatic tick();
    @(negedge TX_CLK);
    chk("tx_data",    32'(TX_DATA),    32'(m_data));
    chk("tx_kchar",   32'(TX_KCHAR),   32'(m_k));
    chk("active_src", 32'(ACTIVE_SRC), 32'(m_act));
    chk("switch_cnt", 32'(SWITCH_CNT), 32'(m_cnt));
    chk("forced",     32'(FORCED),     32'(m_forced));
  endtask

  initial begin : stim
    logic [15:0] w;
    int          bprob;
    RESET_N = 1'b1;
    SRC_EN  = '0;
    CNT_CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin sd[i] = '0; sk[i] = '0; end
    #1 RESET_N = 1'b0;
    @(negedge TX_CLK);
    @(negedge TX_CLK);
    RESET_N = 1'b1;

    // Reset / idle state.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_data", 32'(TX_DATA), 32'h50BC);
      chk("rst_k",    32'(TX_KCHAR), 32'h1);
      chk("rst_act",  32'(ACTIVE_SRC), 32'd3);
      chk("rst_cnt",  32'(SWITCH_CNT), 32'd0);
    end

    // Source 2 alone with a counting pattern.
    SRC_EN = 3'b100; sd[2] = 16'h0001; sk[2] = 2'b00;
    tick();
    chk("off_idle_act", 32'(ACTIVE_SRC), 32'd3);
    sd[2] = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      w = sd[2];
      tick();
      chk("pat_data", 32'(TX_DATA), 32'(w));
      chk("pat_act",  32'(ACTIVE_SRC), 32'd2);
      chk("pat_cnt",  32'(SWITCH_CNT), 32'd1);
      sd[2] = sd[2] + 16'd1;
    end

    // Source 1 requests; source 2 ends its packet with a comma five words later.
    SRC_EN = 3'b110; sd[1] = 16'h1100; sk[1] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      w = 16'hA000 + 16'(i);
      sd[2] = w;
      tick();
      chk("pkt_data",   32'(TX_DATA), 32'(w));
      chk("pkt_act",    32'(ACTIVE_SRC), 32'd2);
      chk("pkt_forced", 32'(FORCED), 32'd0);
    end
    sd[2] = 16'h50BC; sk[2] = 2'b01;
    tick();
    chk("bnd_data", 32'(TX_DATA), 32'h50BC);
    chk("bnd_k",    32'(TX_KCHAR), 32'h1);
    chk("bnd_act",  32'(ACTIVE_SRC), 32'd2);
    sd[2] = 16'h0077; sk[2] = 2'b00;
    for (int i = 0; i < GUARD; i++) begin
      tick();
      chk("gap_act",  32'(ACTIVE_SRC), 32'd3);
      chk("gap_data", 32'(TX_DATA), 32'h50BC);
    end
    tick();
    chk("new_data",   32'(TX_DATA), 32'h1100);
    chk("new_act",    32'(ACTIVE_SRC), 32'd1);
    chk("new_cnt",    32'(SWITCH_CNT), 32'd2);
    chk("new_forced", 32'(FORCED), 32'd0);

    // Back to source 2, then source 0 requests and no comma ever arrives.
    SRC_EN = 3'b100;
    for (int i = 0; i < 4; i++) tick();
    chk("back2_act", 32'(ACTIVE_SRC), 32'd2);
    SRC_EN = 3'b101; sd[0] = 16'h0C0C; sk[0] = 2'b00;
    for (int i = 1; i <= DRAIN_MAX + 1; i++) begin
      sd[2] = 16'h0200 + 16'(i);
      tick();
      chk("drain_forced", 32'(FORCED), (i == DRAIN_MAX + 1) ? 32'd1 : 32'd0);
      chk("drain_act",    32'(ACTIVE_SRC), (i == DRAIN_MAX + 1) ? 32'd3 : 32'd2);
    end
    for (int i = 0; i < GUARD; i++) begin
      tick();
      chk("fgap_act",    32'(ACTIVE_SRC), 32'd3);
      chk("fgap_forced", 32'(FORCED), 32'd0);
    end
    tick();
    chk("f_new_data", 32'(TX_DATA), 32'h0C0C);
    chk("f_new_act",  32'(ACTIVE_SRC), 32'd0);
    chk("f_new_cnt",  32'(SWITCH_CNT), 32'd4);

    // Request appears then withdraws while draining: no switch happens.
    SRC_EN = 3'b100; sd[2] = 16'h2222;
    for (int i = 0; i < 4; i++) tick();
    SRC_EN = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ret_drain_act", 32'(ACTIVE_SRC), 32'd2);
    end
    SRC_EN = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ret_act",  32'(ACTIVE_SRC), 32'd2);
      chk("ret_data", 32'(TX_DATA), 32'h2222);
      chk("ret_cnt",  32'(SWITCH_CNT), 32'd5);
    end

    // Reset pulsed in the middle of a guard run.
    SRC_EN = 3'b010;
    tick();
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_data",   32'(TX_DATA), 32'h50BC);
    chk("arst_k",      32'(TX_KCHAR), 32'h1);
    chk("arst_act",    32'(ACTIVE_SRC), 32'd3);
    chk("arst_cnt",    32'(SWITCH_CNT), 32'd0);
    chk("arst_forced", 32'(FORCED), 32'd0);
    SRC_EN = 3'b000;
    @(negedge TX_CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bprob = (c < 1500) ? 5 : 300;
      if ($urandom_range(7) == 0) SRC_EN = 3'($urandom_range(7));
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(bprob) == 0) begin
          sd[i] = {8'($urandom_range(255)), 8'hBC};
          sk[i] = {1'($urandom_range(1)), 1'b1};
        end else begin
          sd[i] = 16'($urandom_range(65535));
          sk[i] = 2'($urandom_range(3));
        end
      end
      CNT_CLR = ($urandom_range(63) == 0);
      tick();
    end

    // Counter saturation, then a clear that collides with a switch.
    SRC_EN = 3'b000; CNT_CLR = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    chk("sat_start", 32'(SWITCH_CNT), 32'd0);
    for (int n = 0; n < 65537; n++) begin
      SRC_EN = 3'b100;
      tick();
      SRC_EN = 3'b000;
      tick();
    end
    chk("sat_cnt", 32'(SWITCH_CNT), 32'hFFFF);
    SRC_EN = 3'b100; CNT_CLR = 1'b1;
    tick();
    chk("clr_wins", 32'(SWITCH_CNT), 32'd0);
    CNT_CLR = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_prio_mux.md
# tx_prio_mux

Parametrised N-source priority multiplexer feeding the CorePCS TX word interface on the transceiver TX clock. It is the next-generation replacement for the fixed three-way PRBS/marker/fiber TX select. It supports any source count and data width. Source changes happen only on a comma-word boundary of the outgoing stream, followed by a guard run of idle words, so that the link never sees a truncated packet or a glitched word.

## Interface
- NSRC, 3: number of sources; index 0 has highest priority (0=PRBS, 1=MARKER, 2=FIBER in the default build)
- DW, 16: data width per word; multiple of 8
- KW, DW/8: K-char flag width (one bit per byte)
- IDLE_DATA, 16'h50BC: idle/fill word; byte 0 is K28.5
- IDLE_KCHAR, 2'b01: K flags of the idle word
- GUARD, 2: idle words inserted between sources; at least 1
- DRAIN_MAX, 64: maximum number of cycles spent waiting for a boundary before a forced switch; at least 1
---
- TX_CLK  in  1  TX word clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- SRC_EN  in  NSRC  per-source enable
- SRC_DATA  in  NSRC*DW  source words; source i at [i*DW +: DW]
- SRC_KCHAR  in  NSRC*KW  source K flags; source i at [i*KW +: KW]
- TX_DATA  out  DW  registered word to CorePCS
- TX_KCHAR  out  KW  registered K flags to CorePCS
- ACTIVE_SRC  out  $clog2(NSRC+1)  source currently on TX_DATA; the value NSRC means idle
- SWITCH_CNT  out  16  number of completed selections; saturates at 16'hFFFF
- FORCED  out  1  one-cycle pulse when a switch is forced by DRAIN_MAX
- CNT_CLR  in  1  synchronous clear of SWITCH_CNT

## Operation
- Requested source `req` is the lowest index i with SRC_EN[i]=1. If no enable is set, `req` is NSRC (idle).
- A word is a boundary when K flag bit 0 is 1 and data byte 0 equals 8'hBC.
- The state machine has four states: OFF, PASS, DRAIN and GUARD.
  - OFF: outputs idle and ACTIVE_SRC=NSRC. When `req` is less than NSRC, the next state is PASS with `cur` set to `req`, and SWITCH_CNT is incremented.
  - PASS: TX is loaded with source `cur`.
    - If `req` equals `cur`, the block stays in PASS.
    - If SRC_EN[cur]=0, the block forces a switch: TX is loaded with idle, and the next state is GUARD if `req` is less than NSRC, otherwise OFF.
    - If SRC_EN[cur] is still 1 but `req` differs, the next state is DRAIN and the drain counter is cleared.
  - DRAIN: TX is loaded with source `cur`.
    - If `req` returns to `cur`, the next state is PASS; no switch is counted.
    - If the current word is a boundary, it is passed through and the next state is GUARD.
    - If the drain counter reaches DRAIN_MAX-1, or SRC_EN[cur] falls, TX is loaded with idle and the next state is GUARD. FORCED pulses only for the DRAIN_MAX case.
  - GUARD: TX is loaded with idle and ACTIVE_SRC=NSRC for GUARD edges. On the last guard edge `req` is re-sampled: if `req` is less than NSRC, the next state is PASS with `cur` set to `req` and SWITCH_CNT is incremented; otherwise the next state is OFF.
- ACTIVE_SRC always describes the word currently on TX_DATA, so it is updated on the same edge as TX_DATA.
- If CNT_CLR and an increment occur on the same edge, the clear wins.
- Reset asserted in any state takes effect immediately and asynchronously.

## Timing
- Reset values:
  - TX_DATA=IDLE_DATA, TX_KCHAR=IDLE_KCHAR
  - ACTIVE_SRC=NSRC
  - SWITCH_CNT=0, FORCED=0
  - state=OFF
- In PASS and DRAIN the latency is 1 cycle: TX_DATA at edge n+1 equals SRC_DATA[cur] sampled at edge n.
- Boundary switch timeline:
  - The boundary word seen in cycle n appears on TX after edge n+1.
  - Idle is output after edges n+2 through n+1+GUARD.
  - The first new-source word appears after edge n+2+GUARD.
- OFF to PASS: the first source word appears 2 edges after SRC_EN rises.
- No output is combinational from an input.

## Structure
- Package `tx_mux_pkg`:
  - state encoding (OFF, PASS, DRAIN, GUARD)
  - K28_5 = 8'hBC
  - default IDLE_DATA and IDLE_KCHAR constants
  - boundary-test function
- One sub-module, `tx_prio_enc`: a parametrised NSRC-bit lowest-index priority encoder returning `req`, with NSRC meaning none. All other logic lives in the top level.

## Test plan
- After reset, with all enables 0: TX_DATA=16'h50BC, TX_KCHAR=2'b01, ACTIVE_SRC=3 indefinitely, SWITCH_CNT=0.
- Enable source 2 only, feeding a counting pattern 0x0001, 0x0002, …: TX_DATA shows the pattern 1 cycle late, ACTIVE_SRC=2, SWITCH_CNT=1.
- Source 2 active, source 1 enabled mid-packet, source 2 sends 16'h50BC with K=01 five cycles later: five packet words pass, then the boundary word, then 2 idle words, then source 1 data; SWITCH_CNT=2; FORCED stays 0.
- Source 2 active, source 0 enabled, source 2 never sends a boundary: after 64 DRAIN cycles FORCED pulses for 1 cycle, 2 idle words follow, then source 0 data.
- In DRAIN, source 1 is enabled and then disabled before any boundary: the block returns to PASS on source 2, no idle words are inserted and SWITCH_CNT is unchanged. Repeat with RESET_N pulsed low mid-GUARD: all outputs return to their reset values immediately.
- Drive 70000 switches with CNT_CLR held at 0: SWITCH_CNT stops at 16'hFFFF. Assert CNT_CLR on a switching edge: SWITCH_CNT=0.
